// File: rtl/counter12_pkg.sv
// rtl/counter12_pkg.sv - shared types and helpers for the mod-12 counter monitor
//
// Purpose: modulus constants, FSM state and fault-code enums, and the
//          expected-successor function used by counter12_monitor.
// Ports:   none (package).
package counter12_pkg;

  localparam logic [3:0] MOD = 4'd12;
  localparam logic [3:0] MAX = 4'd11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10,
    FAULT   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    RANGE = 2'b01,
    STEP  = 2'b10
  } err_code_e;

  function automatic logic [3:0] next_count(input logic [3:0] p);
    return (p == MAX) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/counter12_monitor.sv
// rtl/counter12_monitor.sv - lock/wrap/fault checker for an upstream mod-12 counter
//
// Purpose: samples q every clock, locks after LOCK_N consecutive correct
//          steps, pulses wrap and counts periods on each 11->0 step while
//          locked, and latches a sticky fault on an illegal value or step.
// Ports:
//   clk      in   system clock shared with the upstream counter
//   rst      in   synchronous active-high reset
//   q        in   4-bit count value under test
//   locked   out  high while locked
//   wrap     out  one-cycle pulse on an accepted 11->0 step
//   periods  out  saturating count of completed periods (CNT_W bits)
//   err      out  sticky fault flag
//   err_code out  00 none, 01 out-of-range value, 10 bad step
//   last_q   out  most recent sample, frozen at the offending value on fault
module counter12_monitor
  import counter12_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       q,
  output logic             locked,
  output logic             wrap,
  output logic [CNT_W-1:0] periods,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [3:0]       last_q
);

  localparam logic [3:0]       LOCK_TARGET = LOCK_N[3:0];
  localparam logic [CNT_W-1:0] PER_ONE     = CNT_W'(1);

  state_e           r_state;
  logic [3:0]       r_prev;
  logic [3:0]       r_good;
  logic             r_locked;
  logic             r_wrap;
  logic [CNT_W-1:0] r_periods;
  logic             r_err;
  err_code_e        r_err_code;
  logic [3:0]       r_last_q;

  state_e           w_state_nxt;
  logic [3:0]       w_prev_nxt;
  logic [3:0]       w_good_nxt;
  logic             w_wrap_nxt;
  logic [CNT_W-1:0] w_periods_nxt;
  err_code_e        w_err_code_nxt;
  logic [3:0]       w_last_q_nxt;
  logic             w_valid;
  logic             w_step_ok;
  logic [3:0]       w_good_inc;

  assign w_valid    = (q < MOD);
  assign w_step_ok  = (q == next_count(r_prev));
  assign w_good_inc = r_good + 4'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_prev_nxt     = r_prev;
    w_good_nxt     = r_good;
    w_wrap_nxt     = 1'b0;
    w_periods_nxt  = r_periods;
    w_err_code_nxt = r_err_code;
    w_last_q_nxt   = r_last_q;

    case (r_state)
      IDLE: begin
        w_prev_nxt   = q;
        w_last_q_nxt = q;
        if (w_valid) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = 4'd0;
        end
      end

      ACQUIRE: begin
        w_prev_nxt   = q;
        w_last_q_nxt = q;
        // Out-of-range values only restart the run: the upstream counter
        // recovers from 12..15 on its own, so they are not a fault here.
        if (!w_valid) begin
          w_good_nxt = 4'd0;
        end else if (w_step_ok) begin
          w_good_nxt = w_good_inc;
          // No wrap/period on the locking step, even if it is 11->0.
          if (w_good_inc == LOCK_TARGET) begin
            w_state_nxt = LOCKED;
          end
        end else begin
          w_good_nxt = 4'd0;
        end
      end

      LOCKED: begin
        w_prev_nxt   = q;
        w_last_q_nxt = q;
        if (!w_valid) begin
          w_state_nxt    = FAULT;
          w_err_code_nxt = RANGE;
        end else if (!w_step_ok) begin
          w_state_nxt    = FAULT;
          w_err_code_nxt = STEP;
        end else if (r_prev == MAX && q == 4'd0) begin
          w_wrap_nxt = 1'b1;
          if (r_periods != '1) begin
            w_periods_nxt = r_periods + PER_ONE;
          end
        end
      end

      FAULT: begin
        // Absorbing: everything holds until rst.
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prev     <= 4'd0;
      r_good     <= 4'd0;
      r_locked   <= 1'b0;
      r_wrap     <= 1'b0;
      r_periods  <= '0;
      r_err      <= 1'b0;
      r_err_code <= NONE;
      r_last_q   <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_prev_nxt;
      r_good     <= w_good_nxt;
      r_locked   <= (w_state_nxt == LOCKED);
      r_wrap     <= w_wrap_nxt;
      r_periods  <= w_periods_nxt;
      r_err      <= (w_state_nxt == FAULT);
      r_err_code <= w_err_code_nxt;
      r_last_q   <= w_last_q_nxt;
    end
  end

  assign locked   = r_locked;
  assign wrap     = r_wrap;
  assign periods  = r_periods;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign last_q   = r_last_q;

endmodule

// File: tb/tb_counter12_monitor.sv
// tb/tb_counter12_monitor.sv - self-checking bench for counter12_monitor
module tb_counter12_monitor;

  localparam int LOCK_N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] q   = 4'd0;

  logic       locked_a, wrap_a, err_a;
  logic [7:0] periods_a;
  logic [1:0] err_code_a;
  logic [3:0] last_q_a;

  logic       locked_b, wrap_b, err_b;
  logic [1:0] periods_b;
  logic [1:0] err_code_b;
  logic [3:0] last_q_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter12_monitor #(.CNT_W(8), .LOCK_N(LOCK_N)) dut_a (
    .clk(clk), .rst(rst), .q(q),
    .locked(locked_a), .wrap(wrap_a), .periods(periods_a),
    .err(err_a), .err_code(err_code_a), .last_q(last_q_a)
  );

  counter12_monitor #(.CNT_W(2), .LOCK_N(LOCK_N)) dut_b (
    .clk(clk), .rst(rst), .q(q),
    .locked(locked_b), .wrap(wrap_b), .periods(periods_b),
    .err(err_b), .err_code(err_code_b), .last_q(last_q_b)
  );

  // Reference model: plain integers, driven from the rules of the checker.
  int m_prev, m_run, m_per8, m_per2, m_code, m_last;
  bit m_started, m_lock, m_fault, m_wrap;

  function automatic int succ(input int p);
    return (p == 11) ? 0 : p + 1;
  endfunction

  function automatic void model_reset();
    m_prev = 0; m_run = 0; m_per8 = 0; m_per2 = 0; m_code = 0; m_last = 0;
    m_started = 0; m_lock = 0; m_fault = 0; m_wrap = 0;
  endfunction

  function automatic void model_step(input int v, input bit r);
    if (r) begin
      model_reset();
      return;
    end
    m_wrap = 0;
    if (m_fault) return;
    m_last = v;
    if (!m_started) begin
      if (v <= 11) begin
        m_started = 1;
        m_run = 0;
      end
    end else if (!m_lock) begin
      if (v > 11) m_run = 0;
      else if (v == succ(m_prev)) begin
        m_run++;
        if (m_run == LOCK_N) m_lock = 1;
      end else m_run = 0;
    end else begin
      if (v > 11) begin
        m_fault = 1; m_lock = 0; m_code = 1;
      end else if (v != succ(m_prev)) begin
        m_fault = 1; m_lock = 0; m_code = 2;
      end else if (m_prev == 11 && v == 0) begin
        m_wrap = 1;
        if (m_per8 < 255) m_per8++;
        if (m_per2 < 3) m_per2++;
      end
    end
    m_prev = v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("locked",    {31'd0, locked_a},   m_lock);
    chk("wrap",      {31'd0, wrap_a},     m_wrap);
    chk("periods",   {24'd0, periods_a},  m_per8);
    chk("err",       {31'd0, err_a},      m_fault);
    chk("err_code",  {30'd0, err_code_a}, m_code);
    chk("last_q",    {28'd0, last_q_a},   m_last);
    chk("periods_w2", {30'd0, periods_b}, m_per2);
    chk("wrap_w2",   {31'd0, wrap_b},     m_wrap);
    chk("err_w2",    {31'd0, err_b},      m_fault);
  endtask

  task automatic tick(input int v, input bit r);
    q   = 4'(v);
    rst = r;
    @(posedge clk);
    model_step(v, r);
    #1;
    check_all();
  endtask

  int cnt;

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    tick(0, 1);
    tick(0, 1);
    chk("rst_locked", {31'd0, locked_a}, 0);
    chk("rst_err", {31'd0, err_a}, 0);
    chk("rst_periods", {24'd0, periods_a}, 0);
    chk("rst_last_q", {28'd0, last_q_a}, 0);

    // Free-running counter from 0: lock after edge 3, wraps every 12
    cnt = 0;
    for (int i = 0; i < 75; i++) begin
      tick(cnt, 0);
      if (i == 1) chk("pre_lock", {31'd0, locked_a}, 0);
      if (i == 2) chk("lock_edge3", {31'd0, locked_a}, 1);
      cnt = succ(cnt);
    end
    chk("periods_after_run", {24'd0, periods_a}, 6);
    chk("periods_w2_sat", {30'd0, periods_b}, 3);
    chk("no_err_run", {31'd0, err_a}, 0);

    // Out-of-range start, then lock after two correct steps
    tick(0, 1);
    tick(13, 0);
    chk("idle_on_13", {31'd0, locked_a}, 0);
    tick(0, 0);
    tick(1, 0);
    chk("one_step", {31'd0, locked_a}, 0);
    tick(2, 0);
    chk("lock_two_steps", {31'd0, locked_a}, 1);
    for (int v = 3; v <= 5; v++) tick(v, 0);
    // Bad step 5 -> 7
    tick(7, 0);
    chk("step_err", {31'd0, err_a}, 1);
    chk("step_code", {30'd0, err_code_a}, 2);
    chk("step_last_q", {28'd0, last_q_a}, 7);
    chk("step_unlock", {31'd0, locked_a}, 0);
    for (int i = 0; i < 20; i++) tick(int'($urandom_range(0, 15)), 0);
    chk("fault_sticky", {31'd0, err_a}, 1);
    chk("fault_last_q", {28'd0, last_q_a}, 7);

    // Reset out of FAULT, lock, then out-of-range value
    tick(0, 1);
    chk("rst_from_fault", {31'd0, err_a}, 0);
    for (int v = 0; v <= 6; v++) tick(v, 0);
    tick(14, 0);
    chk("range_code", {30'd0, err_code_a}, 1);
    chk("range_last_q", {28'd0, last_q_a}, 14);

    // Reset coinciding with a wrap
    tick(0, 1);
    cnt = int'($urandom_range(0, 11));
    for (int i = 0; i < 40; i++) begin
      if (i > 15 && cnt == 0) break;
      tick(cnt, 0);
      cnt = succ(cnt);
    end
    chk("locked_before_rst", {31'd0, locked_a}, 1);
    tick(0, 1);
    chk("rst_wrap_wrap", {31'd0, wrap_a}, 0);
    chk("rst_wrap_locked", {31'd0, locked_a}, 0);
    chk("rst_wrap_periods", {24'd0, periods_a}, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(cnt, 0);
      cnt = succ(cnt);
    end
    chk("relock", {31'd0, locked_a}, 1);

    // Randomised run: counter with occasional glitches, resets after faults
    cnt = int'($urandom_range(0, 11));
    for (int i = 0; i < 500; i++) begin
      if (m_fault && $urandom_range(0, 7) == 0) begin
        tick(int'($urandom_range(0, 15)), 1);
      end else if ($urandom_range(0, 39) == 0) begin
        tick(int'($urandom_range(0, 15)), 0);
      end else begin
        tick(cnt, 0);
      end
      cnt = succ(cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter12_monitor.md
# counter12_monitor

Downstream checker for the mod-12 counter: samples the counter's 4-bit output every clock and verifies that it steps 0→1→…→11→0. It acquires lock after a run of correct steps, pulses on each wrap, counts completed periods, and latches a sticky fault on any illegal value or step once locked. It sits on the same clock as the counter and drives status LEDs and the lab bench's pass/fail indication.

## Interface
- CNT_W, 8: width of the completed-period counter.
- LOCK_N, 2: number of consecutive correct steps required to enter LOCKED (1..15).

- clk  in  1  system clock; the upstream counter uses the same clock.
- rst  in  1  synchronous, active-high reset.
- q  in  4  count value from the upstream mod-12 counter.
- locked  out  1  high while in LOCKED.
- wrap  out  1  one-cycle pulse when an 11→0 step is accepted in LOCKED.
- periods  out  CNT_W  completed periods since lock, saturating.
- err  out  1  sticky fault flag.
- err_code  out  2  00 none, 01 out-of-range value (12..15), 10 bad step.
- last_q  out  4  most recent sample of q; frozen at the offending value in FAULT.

## Operation
- next(p) = (p == 11) ? 0 : p + 1; valid(v) = v ≤ 11.
- prev register holds the previous sample; good counter holds the run of correct steps (4 bits).
- States: IDLE, ACQUIRE, LOCKED, FAULT.
- IDLE: capture q into prev. If valid, go to ACQUIRE with good = 0; otherwise stay in IDLE.
- ACQUIRE: if !valid(q), set good = 0 (no fault; the upstream counter self-recovers from 12..15). If q == next(prev), increment good and go to LOCKED when good + 1 == LOCK_N. Any other valid q sets good = 0. prev ← q every cycle.
- LOCKED:
  - !valid(q): go to FAULT with err_code 01.
  - q != next(prev): go to FAULT with err_code 10.
  - Otherwise stay in LOCKED. If prev == 11 and q == 0, pulse wrap and increment periods, saturating at all ones.
- FAULT: absorbing until rst. err = 1; err_code, last_q and periods hold. locked = 0, wrap = 0.
- Entering LOCKED does not clear periods. periods is cleared only by rst.

## Timing
- All outputs are registered. A decision on the sample taken at edge k is visible right after edge k.
- Reset values: state IDLE, locked 0, wrap 0, periods 0, err 0, err_code 00, last_q 0, prev 0, good 0.
- rst has priority over every other event in the same cycle. A reset mid-operation (including from FAULT) returns to IDLE with all outputs at reset values on the next cycle.
- Lock latency with a free-running counter: locked rises after edge LOCK_N+1 following reset release (edge 3 for LOCK_N = 2).
- wrap is asserted in the cycle after the edge that sampled q == 0, concurrent with the new periods value.
- Fault latency: err rises after the edge that samples the illegal value. last_q shows that value from then on.
- Wrap on the lock edge: if the LOCK_N-th correct step is 11→0, locked rises but wrap does not pulse and periods does not increment. Counting starts with the first wrap seen in LOCKED.

## Structure
- Package counter12_pkg:
  - MOD = 12 and MAX = 11.
  - state enum (IDLE, ACQUIRE, LOCKED, FAULT).
  - err_code enum (NONE = 00, RANGE = 01, STEP = 10).
  - function next_count(logic [3:0]) returning logic [3:0].
- Single module with no sub-module. The saturating period counter is inline.

## Test plan
- Reset, then drive the real counter from q = 0 → locked = 1 after edge 3; wrap pulses every 12 cycles; periods = 1, 2, 3…; err = 0.
- Drive q = 13, 0, 1, 2, … → stays in IDLE/ACQUIRE during 13; locks after 2 correct steps; no err.
- Once locked, force q from 5 to 7 → err = 1, err_code = 10, last_q = 7, locked = 0; stays so for 20 cycles regardless of q.
- Once locked, force q = 14 → err_code = 01, last_q = 14.
- CNT_W = 2, run 5 periods → periods = 1, 2, 3, 3, 3 with wrap still pulsing.
- Assert rst while in FAULT and in the same cycle as a wrap → next cycle all outputs at reset values; re-lock proceeds normally.
